// File: rtl/ball_ctrl.sv
// Per-frame game-state engine: moves the 8x8 ball, resolves wall/paddle collisions and misses,
// escalates ball speed and tracks lives. Every output is a register.
module ball_ctrl #(
   parameter int TOP_MARGIN     = 25,
   parameter int LIVES          = 3,
   parameter int HITS_PER_LEVEL = 4,
   parameter int MISS_FRAMES    = 60,
   parameter int SERVE_X        = 316,
   parameter int SERVE_Y        = 248
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       start,
   input  logic [9:0] paddle1_y,
   input  logic [9:0] paddle2_y,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic [3:0] ball_speed,
   output logic [2:0] lives,
   output logic       game_over,
   output logic       hit,
   output logic       miss_l,
   output logic       miss_r
);

   typedef enum logic [1:0] {S_SERVE, S_PLAY, S_MISS, S_OVER} state_t;

   localparam int          HW      = $clog2(HITS_PER_LEVEL + 1);
   localparam int          MW      = $clog2(MISS_FRAMES + 1);
   localparam logic [10:0] L_TOP   = 11'(TOP_MARGIN);
   localparam logic [9:0]  L_TOP10 = 10'(TOP_MARGIN);
   localparam logic [9:0]  L_SX    = 10'(SERVE_X);
   localparam logic [9:0]  L_SY    = 10'(SERVE_Y);
   localparam logic [3:0]  SPD_MIN = 4'd2;
   localparam logic [3:0]  SPD_MAX = 4'd5;

   state_t          r_state;
   logic [9:0]      r_ball_x, r_ball_y;
   logic [3:0]      r_speed;
   logic [2:0]      r_lives;
   logic            r_dx, r_dy, r_serve_dx;   // dx: 1 = right, dy: 1 = down
   logic [HW-1:0]   r_hit_cnt;
   logic [MW-1:0]   r_miss_cnt;
   logic            r_game_over, r_hit, r_miss_l, r_miss_r;

   logic [10:0] w_s, w_x, w_y, w_p1_top, w_p2_top;
   logic [9:0]  w_step;
   logic        w_p1_ov, w_p2_ov;
   logic [9:0]  w_nx, w_ny;
   logic        w_ndx, w_ndy, w_bounce, w_pass_l, w_pass_r;

   // All collision compares are 11-bit so paddle_y + margin + 72 cannot wrap.
   assign w_s      = {7'd0, r_speed};
   assign w_step   = {6'd0, r_speed};
   assign w_x      = {1'b0, r_ball_x};
   assign w_y      = {1'b0, r_ball_y};
   assign w_p1_top = {1'b0, paddle1_y} + L_TOP;
   assign w_p2_top = {1'b0, paddle2_y} + L_TOP;
   assign w_p1_ov  = (w_y + 11'd7 >= w_p1_top) && (w_y <= w_p1_top + 11'd72);
   assign w_p2_ov  = (w_y + 11'd7 >= w_p2_top) && (w_y <= w_p2_top + 11'd72);

   // NOTE: every signal gets a default before the branches, so no latch can be inferred.
   always_comb begin
      w_ny  = r_ball_y;
      w_ndy = r_dy;
      if (!r_dy) begin
         if (w_y <= L_TOP + w_s) begin
            w_ny  = L_TOP10;
            w_ndy = 1'b1;
         end else begin
            w_ny = r_ball_y - w_step;
         end
      end else if (w_y + 11'd7 + w_s >= 11'd479) begin
         w_ny  = 10'd472;
         w_ndy = 1'b0;
      end else begin
         w_ny = r_ball_y + w_step;
      end
   end

   always_comb begin
      w_nx     = r_ball_x;
      w_ndx    = r_dx;
      w_bounce = 1'b0;
      w_pass_l = 1'b0;
      w_pass_r = 1'b0;
      if (!r_dx) begin
         if (w_x <= 11'd40 + w_s) begin
            if (w_p1_ov) begin
               w_nx     = 10'd41;
               w_ndx    = 1'b1;
               w_bounce = 1'b1;
            end else if (w_x < 11'd32 + w_s) begin
               w_pass_l = 1'b1;
            end else begin
               w_nx = r_ball_x - w_step;
            end
         end else begin
            w_nx = r_ball_x - w_step;
         end
      end else begin
         if (w_x + 11'd7 + w_s >= 11'd600) begin
            if (w_p2_ov) begin
               w_nx     = 10'd592;
               w_ndx    = 1'b0;
               w_bounce = 1'b1;
            end else if (w_x + 11'd7 + w_s > 11'd608) begin
               w_pass_r = 1'b1;
            end else begin
               w_nx = r_ball_x + w_step;
            end
         end else begin
            w_nx = r_ball_x + w_step;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_SERVE;
         r_ball_x    <= L_SX;
         r_ball_y    <= L_SY;
         r_speed     <= SPD_MIN;
         r_lives     <= 3'(LIVES);
         r_dx        <= 1'b1;
         r_dy        <= 1'b1;
         r_serve_dx  <= 1'b1;
         r_hit_cnt   <= '0;
         r_miss_cnt  <= '0;
         r_game_over <= 1'b0;
         r_hit       <= 1'b0;
         r_miss_l    <= 1'b0;
         r_miss_r    <= 1'b0;
      end else begin
         r_hit    <= 1'b0;
         r_miss_l <= 1'b0;
         r_miss_r <= 1'b0;
         if (frame_tick) begin
            unique case (r_state)
               S_SERVE: begin
                  r_ball_x  <= L_SX;
                  r_ball_y  <= L_SY;
                  r_speed   <= SPD_MIN;
                  r_hit_cnt <= '0;
                  if (start) r_state <= S_PLAY;
               end
               S_PLAY: begin
                  r_ball_x <= w_nx;
                  r_ball_y <= w_ny;
                  r_dx     <= w_ndx;
                  r_dy     <= w_ndy;
                  if (w_bounce) begin
                     r_hit <= 1'b1;
                     if (r_hit_cnt == HW'(HITS_PER_LEVEL - 1)) begin
                        r_hit_cnt <= '0;
                        if (r_speed < SPD_MAX) r_speed <= r_speed + 4'd1;
                     end else begin
                        r_hit_cnt <= r_hit_cnt + 1'b1;
                     end
                  end
                  if (w_pass_l || w_pass_r) begin
                     r_miss_l   <= w_pass_l;
                     r_miss_r   <= w_pass_r;
                     r_serve_dx <= w_pass_r;
                     r_miss_cnt <= '0;
                     r_state    <= S_MISS;
                     if (r_lives != 3'd0) r_lives <= r_lives - 3'd1;
                  end
               end
               S_MISS: begin
                  if (r_miss_cnt == MW'(MISS_FRAMES - 1)) begin
                     if (r_lives == 3'd0) begin
                        r_state     <= S_OVER;
                        r_game_over <= 1'b1;
                     end else begin
                        r_state   <= S_SERVE;
                        r_ball_x  <= L_SX;
                        r_ball_y  <= L_SY;
                        r_dx      <= r_serve_dx;
                        r_speed   <= SPD_MIN;
                        r_hit_cnt <= '0;
                     end
                  end else begin
                     r_miss_cnt <= r_miss_cnt + 1'b1;
                  end
               end
               S_OVER: begin
                  if (start) begin
                     r_state     <= S_SERVE;
                     r_game_over <= 1'b0;
                     r_lives     <= 3'(LIVES);
                     r_dx        <= 1'b1;
                     r_ball_x    <= L_SX;
                     r_ball_y    <= L_SY;
                     r_speed     <= SPD_MIN;
                     r_hit_cnt   <= '0;
                  end
               end
               default: r_state <= S_SERVE;
            endcase
         end
      end
   end

   assign ball_x     = r_ball_x;
   assign ball_y     = r_ball_y;
   assign ball_speed = r_speed;
   assign lives      = r_lives;
   assign game_over  = r_game_over;
   assign hit        = r_hit;
   assign miss_l     = r_miss_l;
   assign miss_r     = r_miss_r;

endmodule

// File: tb/tb_ball_ctrl.sv
// Bench for ball_ctrl: directed phases plus randomized play, every cycle compared against
// an integer game model derived from the game rules.
module tb_ball_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       frame_tick = 1'b0;
   logic       start = 1'b0;
   logic [9:0] paddle1_y = '0;
   logic [9:0] paddle2_y = '0;
   logic [9:0] ball_x, ball_y;
   logic [3:0] ball_speed;
   logic [2:0] lives;
   logic       game_over, hit, miss_l, miss_r;

   always #5 clk = ~clk;

   ball_ctrl dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
      .paddle1_y(paddle1_y), .paddle2_y(paddle2_y),
      .ball_x(ball_x), .ball_y(ball_y), .ball_speed(ball_speed), .lives(lives),
      .game_over(game_over), .hit(hit), .miss_l(miss_l), .miss_r(miss_r)
   );

   localparam int M_SERVE = 0, M_PLAY = 1, M_MISS = 2, M_OVER = 3;

   int n_tests = 0, n_fail = 0;
   int mode, mx, my, mdx, mdy, mspd, mlives, mhits, mfrz, mserve_dx, mgo;
   int eh, eml, emr;
   int hits_seen;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic recenter();
      mx = 316; my = 248; mspd = 2; mhits = 0;
   endtask

   task automatic model_reset();
      mode = M_SERVE; recenter(); mdx = 1; mdy = 1; mlives = 3; mgo = 0; mfrz = 0;
      mserve_dx = 1;
   endtask

   function automatic bit overlaps(input int y, input int p);
      return (y + 7 >= p + 25) && (y <= p + 25 + 72);
   endfunction

   task automatic model_tick(input bit st, input int p1, input int p2);
      int s, ny, ndy;
      case (mode)
         M_SERVE: begin
            recenter();
            if (st) mode = M_PLAY;
         end
         M_PLAY: begin
            s = mspd; ny = my; ndy = mdy;
            if (mdy < 0) begin
               if (my <= 25 + s) begin ny = 25; ndy = 1; end else ny = my - s;
            end else begin
               if (my + 7 + s >= 479) begin ny = 472; ndy = -1; end else ny = my + s;
            end
            if (mdx < 0) begin
               if (mx <= 40 + s && overlaps(my, p1)) begin mx = 41; mdx = 1; eh = 1; end
               else if (mx <= 40 + s && mx < 32 + s) eml = 1;
               else mx = mx - s;
            end else begin
               if (mx + 7 + s >= 600 && overlaps(my, p2)) begin mx = 592; mdx = -1; eh = 1; end
               else if (mx + 7 + s > 608) emr = 1;
               else mx = mx + s;
            end
            my = ny; mdy = ndy;
            if (eh != 0) begin
               hits_seen++;
               mhits++;
               if (mhits == 4) begin
                  mhits = 0;
                  if (mspd < 5) mspd++;
               end
            end
            if (eml != 0 || emr != 0) begin
               if (mlives > 0) mlives--;
               mode = M_MISS; mfrz = 0;
               mserve_dx = (emr != 0) ? 1 : -1;
            end
         end
         M_MISS: begin
            mfrz++;
            if (mfrz == 60) begin
               if (mlives == 0) begin
                  mode = M_OVER; mgo = 1;
               end else begin
                  mode = M_SERVE; recenter(); mdx = mserve_dx;
               end
            end
         end
         default: begin
            if (st) begin
               mode = M_SERVE; mgo = 0; mlives = 3; mdx = 1; recenter();
            end
         end
      endcase
   endtask

   task automatic check_all();
      check("ball_x", ball_x, mx);
      check("ball_y", ball_y, my);
      check("ball_speed", ball_speed, mspd);
      check("lives", lives, mlives);
      check("game_over", game_over, mgo);
      check("hit", hit, eh);
      check("miss_l", miss_l, eml);
      check("miss_r", miss_r, emr);
   endtask

   task automatic step(input bit rst, input bit tk, input bit st, input int p1, input int p2);
      @(negedge clk);
      reset = rst; frame_tick = tk; start = st;
      paddle1_y = p1[9:0]; paddle2_y = p2[9:0];
      @(posedge clk);
      #1;
      eh = 0; eml = 0; emr = 0;
      if (rst) model_reset();
      else if (tk) model_tick(st, p1, p2);
      check_all();
   endtask

   function automatic int track();
      int v;
      v = my - 25 - int'($urandom_range(0, 60));
      return (v < 0) ? 0 : v;
   endfunction

   function automatic int far_pad();
      return (my < 240) ? 380 : 0;
   endfunction

   initial begin
      int n, r, p1, p2;
      bit lvl1_checked;
      model_reset();
      hits_seen = 0;
      lvl1_checked = 0;

      // Reset (start/tick ignored while reset is high), then idle ticks in SERVE.
      step(1, 0, 0, 0, 0);
      step(1, 1, 1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 0, 100, 200);
         step(0, 0, 0, 100, 200);
      end
      check("serve_hold_x", ball_x, 316);
      check("serve_hold_y", ball_y, 248);

      // Perfect paddles: speed climbs one level per four hits and saturates at 5.
      step(0, 1, 1, 0, 0);
      n = 0;
      while (hits_seen < 24 && n < 20000) begin
         p1 = track(); p2 = track();
         step(0, 1, 0, p1, p2);
         if (hits_seen == 4 && !lvl1_checked) begin
            check("speed_level1", ball_speed, 3);
            lvl1_checked = 1;
         end
         n++;
      end
      check("phaseA_done", (hits_seen >= 24) ? 1 : 0, 1);
      check("speed_saturated", ball_speed, 5);
      check("lives_after_hits", lives, 3);

      // Paddles always away from the ball: three misses end the game.
      n = 0;
      while (mgo == 0 && n < 20000) begin
         p1 = far_pad(); p2 = far_pad();
         step(0, 1, 1, p1, p2);
         n++;
      end
      check("phaseB_done", mgo, 1);
      check("over_flag", game_over, 1);
      check("over_lives", lives, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
      step(0, 1, 1, 0, 0);
      check("restart_lives", lives, 3);
      check("restart_over", game_over, 0);

      // Randomized play with irregular ticks, sporadic starts, mixed paddles, rare resets.
      for (int i = 0; i < 12000; i++) begin
         r = int'($urandom_range(0, 9));
         if (r < 7) begin p1 = track(); p2 = track(); end
         else if (r < 9) begin p1 = far_pad(); p2 = far_pad(); end
         else begin p1 = int'($urandom_range(0, 1023)); p2 = int'($urandom_range(0, 1023)); end
         step(($urandom_range(0, 2999) == 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 7) == 0), p1, p2);
      end

      // Reset in the middle of a rally must restore power-up values.
      n = 0;
      while (mode != M_PLAY && n < 20000) begin
         step(0, 1, 1, 0, 0);
         n++;
      end
      for (int i = 0; i < 20; i++) step(0, 1, 0, track(), track());
      step(1, 1, 1, 0, 0);
      check("midreset_x", ball_x, 316);
      check("midreset_y", ball_y, 248);
      check("midreset_speed", ball_speed, 2);
      check("midreset_lives", lives, 3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
